// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit: load-use stalls across NUM_EX execute stages,
// redirect flushing, MDU start/hold/kill FSM and saturating stall/flush counters.

module hazard_lu_cmp #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rd_i,
  input  logic              load_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              rs1_use_i,
  input  logic              rs2_use_i,
  output logic              lu_o
);
  // x0 never carries a real dependency
  assign lu_o = load_i && (rd_i != '0) &&
                ((rs1_use_i && (rd_i == rs1_i)) || (rs2_use_i && (rd_i == rs2_i)));
endmodule

module hazard_ctrl #(
  parameter int NUM_EX = 2,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [REG_AW-1:0]        rs1_d_i,
  input  logic [REG_AW-1:0]        rs2_d_i,
  input  logic                     rs1_use_d_i,
  input  logic                     rs2_use_d_i,
  input  logic                     mdu_op_d_i,
  input  logic [NUM_EX*REG_AW-1:0] rd_e_i,
  input  logic [NUM_EX-1:0]        load_e_i,
  input  logic [NUM_EX-1:0]        redirect_e_i,
  input  logic                     mdu_done_i,
  output logic                     stall_f_o,
  output logic                     stall_d_o,
  output logic                     flush_d_o,
  output logic [NUM_EX-1:0]        flush_e_o,
  output logic                     mdu_start_o,
  output logic                     mdu_kill_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         flush_cnt_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [NUM_EX-1:0]  lu_e;
  logic [NUM_EX-1:0]  redir_mask;
  logic               lu, redir, start_c, hold;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

  for (genvar k = 0; k < NUM_EX; k++) begin : g_stage
    hazard_lu_cmp #(.REG_AW(REG_AW)) u_cmp (
      .rd_i      (rd_e_i[k*REG_AW +: REG_AW]),
      .load_i    (load_e_i[k]),
      .rs1_i     (rs1_d_i),
      .rs2_i     (rs2_d_i),
      .rs1_use_i (rs1_use_d_i),
      .rs2_use_i (rs2_use_d_i),
      .lu_o      (lu_e[k])
    );
  end

  assign lu      = |lu_e;
  assign redir   = |redirect_e_i;
  assign start_c = mdu_op_d_i && !lu && !redir;

  // Stage j is flushed when any stage at or beyond it redirects (oldest wins).
  always_comb begin
    redir_mask = '0;
    for (int j = 0; j < NUM_EX; j++) redir_mask[j] = |(redirect_e_i >> j);
  end

  always_comb begin
    state_d     = state_q;
    mdu_start_o = 1'b0;
    mdu_kill_o  = 1'b0;
    case (state_q)
      IDLE: if (start_c) begin
        state_d     = BUSY;
        mdu_start_o = n_rst;
      end
      BUSY: if (redir) begin
        state_d    = IDLE;
        mdu_kill_o = 1'b1;
      end else if (mdu_done_i) begin
        state_d = IDLE;
      end
    endcase
  end

  assign hold = lu || ((state_q == IDLE) && start_c) || ((state_q == BUSY) && !mdu_done_i);

  always_comb begin
    stall_f_o = hold;
    stall_d_o = hold;
    flush_d_o = 1'b0;
    flush_e_o = '0;
    flush_e_o[0] = hold;
    if (redir) begin
      stall_f_o = 1'b0;
      stall_d_o = 1'b0;
      flush_d_o = 1'b1;
      flush_e_o = redir_mask;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall_d_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_d_o && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.

module tb_hazard_ctrl;
  localparam int NUM_EX  = 2;
  localparam int REG_AW  = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                            clk = 1'b0;
  logic                            n_rst = 1'b0;
  logic [REG_AW-1:0]               rs1, rs2;
  logic                            rs1_use, rs2_use, mdu_op, mdu_done;
  logic [NUM_EX-1:0][REG_AW-1:0]   rd_arr;
  logic [NUM_EX*REG_AW-1:0]        rd_e;
  logic [NUM_EX-1:0]               load_e, redirect_e;
  logic                            stall_f, stall_d, flush_d, mdu_start, mdu_kill;
  logic [NUM_EX-1:0]               flush_e;
  logic [CNT_W-1:0]                stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  assign rd_e = rd_arr;

  hazard_ctrl #(.NUM_EX(NUM_EX), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rs1_d_i      (rs1),
    .rs2_d_i      (rs2),
    .rs1_use_d_i  (rs1_use),
    .rs2_use_d_i  (rs2_use),
    .mdu_op_d_i   (mdu_op),
    .rd_e_i       (rd_e),
    .load_e_i     (load_e),
    .redirect_e_i (redirect_e),
    .mdu_done_i   (mdu_done),
    .stall_f_o    (stall_f),
    .stall_d_o    (stall_d),
    .flush_d_o    (flush_d),
    .flush_e_o    (flush_e),
    .mdu_start_o  (mdu_start),
    .mdu_kill_o   (mdu_kill),
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    rs1 = '0; rs2 = '0; rs1_use = 0; rs2_use = 0; mdu_op = 0; mdu_done = 0;
    rd_arr = '0; load_e = '0; redirect_e = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu();
    load_e = 2'b01; rd_arr[0] = 5'd5; rs1 = 5'd5; rs1_use = 1;
  endtask

  // Behavioural model: MDU busy flag plus two saturating integer counters.
  bit m_busy;
  int m_sc, m_fc;

  always @(negedge clk) begin : cmp
    bit e_lu, e_redir, e_start, e_kill, e_hold, e_stall;
    int kmax, e_fe;
    if (!n_rst) begin
      m_busy = 0; m_sc = 0; m_fc = 0;
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      chk("rst_flush_cnt", 32'(flush_cnt), 0);
      chk("rst_start", 32'(mdu_start), 0);
      chk("rst_kill", 32'(mdu_kill), 0);
    end else begin
      e_lu = 0; kmax = -1;
      for (int k = 0; k < NUM_EX; k++) begin
        if (load_e[k] && rd_arr[k] != 0 &&
            ((rs1_use && rd_arr[k] == rs1) || (rs2_use && rd_arr[k] == rs2))) e_lu = 1;
        if (redirect_e[k]) kmax = k;
      end
      e_redir = (kmax >= 0);
      if (e_redir) begin
        e_start = 0; e_kill = m_busy; e_stall = 0;
        e_fe = (1 << (kmax + 1)) - 1;
        m_busy = 0;
      end else begin
        e_start = !m_busy && mdu_op && !e_lu;
        e_hold  = e_lu || e_start || (m_busy && !mdu_done);
        e_kill = 0; e_stall = e_hold; e_fe = e_hold ? 1 : 0;
        m_busy = m_busy ? !mdu_done : e_start;
      end
      chk("stall_f", 32'(stall_f), 32'(e_stall));
      chk("stall_d", 32'(stall_d), 32'(e_stall));
      chk("flush_d", 32'(flush_d), 32'(e_redir));
      chk("flush_e", 32'(flush_e), e_fe);
      chk("mdu_start", 32'(mdu_start), 32'(e_start));
      chk("mdu_kill", 32'(mdu_kill), 32'(e_kill));
      chk("stall_cnt", 32'(stall_cnt), m_sc);
      chk("flush_cnt", 32'(flush_cnt), m_fc);
      if (e_stall) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : m_sc;
      if (e_redir) m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : m_fc;
    end
  end

  initial begin
    clr();
    #2;
    chk("lit_rst_cnt", 32'(stall_cnt), 0);
    chk("lit_rst_start", 32'(mdu_start), 0);
    cyc(); n_rst = 1;

    // load-use: load passes E0 then E1, D stalls two cycles
    cyc(); clr(); set_lu(); #1;
    chk("lit_lu_stall_f", 32'(stall_f), 1);
    chk("lit_lu_flush_e", 32'(flush_e), 32'b01);
    cyc(); load_e = 2'b10; rd_arr[1] = 5'd5; rd_arr[0] = '0; #1;
    chk("lit_lu_e1_stall", 32'(stall_d), 1);
    cyc(); load_e = '0; #1;
    chk("lit_lu_release", 32'(stall_d), 0);
    chk("lit_lu_cnt", 32'(stall_cnt), 2);

    // x0 and unused source never stall
    cyc(); clr(); load_e = 2'b10; rs2 = '0; rs2_use = 1; #1;
    chk("lit_x0", 32'(stall_d), 0);
    cyc(); rd_arr[1] = 5'd3; rs2 = 5'd3; rs2_use = 0; #1;
    chk("lit_nouse", 32'(stall_d), 0);

    // redirect overrides load-use
    cyc(); clr(); set_lu(); redirect_e = 2'b10; #1;
    chk("lit_redir_fd", 32'(flush_d), 1);
    chk("lit_redir_fe", 32'(flush_e), 32'b11);
    chk("lit_redir_sf", 32'(stall_f), 0);
    cyc(); clr(); #1;
    chk("lit_redir_cnt", 32'(flush_cnt), 1);

    // MDU: start, 6 stall cycles, release on done
    cyc(); n_rst = 0; clr(); #1;
    chk("lit_rst2_cnt", 32'(stall_cnt), 0);
    cyc(); n_rst = 1; mdu_op = 1; #1;
    chk("lit_mdu_start", 32'(mdu_start), 1);
    chk("lit_mdu_stall", 32'(stall_d), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("lit_mdu_busy_start", 32'(mdu_start), 0);
      chk("lit_mdu_busy_stall", 32'(stall_d), 1);
    end
    cyc(); mdu_done = 1; #1;
    chk("lit_mdu_done_stall", 32'(stall_d), 0);
    cyc(); clr(); mdu_op = 1; #1;
    chk("lit_mdu_cnt", 32'(stall_cnt), 6);
    chk("lit_mdu_idle_start", 32'(mdu_start), 1);

    // kill: redirect with done while busy
    cyc(); cyc();
    cyc(); redirect_e = 2'b01; mdu_done = 1; #1;
    chk("lit_kill", 32'(mdu_kill), 1);
    chk("lit_kill_fd", 32'(flush_d), 1);
    chk("lit_kill_stall", 32'(stall_d), 0);
    cyc(); clr(); #1;
    chk("lit_kill_after", 32'(stall_d), 0);
    cyc(); mdu_op = 1; #1;
    chk("lit_kill_idle", 32'(mdu_start), 1);
    cyc(); clr(); redirect_e = 2'b01; #1;

    // saturation and mid-BUSY reset
    cyc(); n_rst = 0; clr();
    cyc(); n_rst = 1; set_lu();
    repeat (20) cyc();
    cyc(); clr(); #1;
    chk("lit_stall_sat", 32'(stall_cnt), 15);
    repeat (20) begin cyc(); redirect_e = 2'b10; end
    cyc(); clr(); #1;
    chk("lit_flush_sat", 32'(flush_cnt), 15);
    cyc(); mdu_op = 1;
    cyc(); cyc();
    cyc(); n_rst = 0; mdu_op = 0; #1;
    chk("lit_midrst_sc", 32'(stall_cnt), 0);
    chk("lit_midrst_fc", 32'(flush_cnt), 0);
    chk("lit_midrst_stall", 32'(stall_d), 0);
    cyc(); n_rst = 1; #1;
    chk("lit_midrst_idle", 32'(stall_d), 0);

    // randomized run
    repeat (3000) begin
      cyc();
      n_rst      = ($urandom_range(0, 199) != 0);
      rs1        = REG_AW'($urandom_range(0, 3));
      rs2        = REG_AW'($urandom_range(0, 3));
      rs1_use    = 1'($urandom);
      rs2_use    = 1'($urandom);
      for (int k = 0; k < NUM_EX; k++) rd_arr[k] = REG_AW'($urandom_range(0, 3));
      load_e     = NUM_EX'($urandom);
      redirect_e = ($urandom_range(0, 7) == 0) ? NUM_EX'($urandom_range(1, 3)) : '0;
      mdu_op     = ($urandom_range(0, 2) == 0);
      mdu_done   = ($urandom_range(0, 5) == 0);
    end
    cyc(); clr();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
